vfp_cfg_sequencer: RTL and testbench

AXI4-Lite master that programs the VFP register bank from a small external configuration table after a start pulse. Writes every entry in sequence, then optionally reads each register back and compares it with the table value. Reports done, error and the failing index to the control plane. Sits between the system control logic and the VFP AXI4-Lite slave port, and replaces software bring-up of the register bank.

---
 rtl/vfp_cfg_pkg.sv | 24 ++
 rtl/vfp_cfg_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_vfp_cfg_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vfp_cfg_pkg.sv
// Shared types and constants for the VFP configuration sequencer.
// Holds the FSM state encoding, the first-error cause codes and the AXI response codes.
package vfp_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR,
        WB,
        RFETCH,
        RA,
        RD,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BRESP = 2'd1;
    localparam logic [1:0] ERR_RRESP = 2'd2;
    localparam logic [1:0] ERR_DATA  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/vfp_cfg_sequencer.sv
// AXI4-Lite master that writes a configuration table into the VFP register bank and
// optionally reads it back, reporting the first failing entry and its cause.
module vfp_cfg_sequencer
    import vfp_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int VERIFY     = 1,
    parameter int TIMEOUT    = 1023,
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    output logic [IDX_W-1:0]        tbl_idx,
    input  logic [ADDR_WIDTH-1:0]   tbl_addr,
    input  logic [DATA_WIDTH-1:0]   tbl_data,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [IDX_W-1:0]        err_idx,
    output logic [1:0]              err_kind,
    output logic                    err_to
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [IDX_W-1:0]        r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic [IDX_W-1:0]        r_err_idx;
    logic [1:0]              r_err_kind;
    logic                    r_err_to;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_last;
    logic                    w_tmo;
    logic                    w_rec;
    logic [1:0]              w_rec_kind;
    logic                    w_rec_to;

    assign m_axi_awvalid = (r_state == WR) && !r_aw_done;
    assign m_axi_wvalid  = (r_state == WR) && !r_w_done;
    assign m_axi_bready  = (r_state == WB);
    assign m_axi_arvalid = (r_state == RA);
    assign m_axi_rready  = (r_state == RD);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_data;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wstrb   = '1;

    assign tbl_idx  = r_idx;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign err_idx  = r_err_idx;
    assign err_kind = r_err_kind;
    assign err_to   = r_err_to;

    assign w_aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_w_hs  = m_axi_wvalid && m_axi_wready;
    assign w_last  = (r_idx == IDX_W'(NUM_REGS - 1));
    assign w_tmo   = (r_cnt >= TMO);

    always_comb begin
        w_state_nx = r_state;
        w_rec      = 1'b0;
        w_rec_kind = ERR_NONE;
        w_rec_to   = 1'b0;
        case (r_state)
            IDLE:   if (start) w_state_nx = FETCH;
            FETCH:  w_state_nx = WR;
            RFETCH: w_state_nx = RA;
            WR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nx = WB;
                end else if (w_tmo) begin
                    w_state_nx = DONE;
                    w_rec      = 1'b1;
                    w_rec_kind = ERR_DATA;
                    w_rec_to   = 1'b1;
                end
            end
            WB: begin
                if (m_axi_bvalid) begin
                    w_rec      = (m_axi_bresp != RESP_OKAY);
                    w_rec_kind = ERR_BRESP;
                    if (!w_last)         w_state_nx = FETCH;
                    else if (VERIFY != 0) w_state_nx = RFETCH;
                    else                 w_state_nx = DONE;
                end else if (w_tmo) begin
                    w_state_nx = DONE;
                    w_rec      = 1'b1;
                    w_rec_kind = ERR_DATA;
                    w_rec_to   = 1'b1;
                end
            end
            RA: begin
                if (m_axi_arready) begin
                    w_state_nx = RD;
                end else if (w_tmo) begin
                    w_state_nx = DONE;
                    w_rec      = 1'b1;
                    w_rec_kind = ERR_DATA;
                    w_rec_to   = 1'b1;
                end
            end
            RD: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != RESP_OKAY) begin
                        w_rec      = 1'b1;
                        w_rec_kind = ERR_RRESP;
                    end else if (m_axi_rdata != r_data) begin
                        w_rec      = 1'b1;
                        w_rec_kind = ERR_DATA;
                    end
                    w_state_nx = w_last ? DONE : RFETCH;
                end else if (w_tmo) begin
                    w_state_nx = DONE;
                    w_rec      = 1'b1;
                    w_rec_kind = ERR_DATA;
                    w_rec_to   = 1'b1;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
            r_err_kind <= ERR_NONE;
            r_err_to   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            // The wait counter restarts on every state change, so each handshake gets its own budget.
            if (w_state_nx != r_state) r_cnt <= '0;
            else if (r_cnt != '1)      r_cnt <= r_cnt + CNT_W'(1);

            r_aw_done <= (r_state == WR) && (w_state_nx == WR) && (r_aw_done || w_aw_hs);
            r_w_done  <= (r_state == WR) && (w_state_nx == WR) && (r_w_done || w_w_hs);

            if (r_state == FETCH || r_state == RFETCH) begin
                r_addr <= tbl_addr;
                r_data <= tbl_data;
            end

            if (r_state == IDLE && start) begin
                r_idx <= '0;
            end else if ((r_state == WB && m_axi_bvalid) || (r_state == RD && m_axi_rvalid)) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end

            if (r_state == IDLE && start) begin
                r_err      <= 1'b0;
                r_err_idx  <= '0;
                r_err_kind <= ERR_NONE;
                r_err_to   <= 1'b0;
            end else if (w_rec && !r_err) begin
                r_err      <= 1'b1;
                r_err_idx  <= r_idx;
                r_err_kind <= w_rec_kind;
                r_err_to   <= w_rec_to;
            end
        end
    end

endmodule

// File: tb/tb_vfp_cfg_sequencer.sv
// Bench for vfp_cfg_sequencer: a configurable AXI4-Lite slave with delay and error
// injection, a table of directed scenarios, hand sequences and randomized runs.
module tb_vfp_cfg_sequencer;

    localparam int TMO = 40;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  tbl_idx;
    logic [3:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        busy, done, err, err_to;
    logic [1:0]  err_idx, err_kind;

    logic        n_start = 1'b0;
    logic [1:0]  n_tbl_idx;
    logic [3:0]  n_awaddr, n_araddr;
    logic [2:0]  n_awprot, n_arprot;
    logic        n_awvalid, n_wvalid, n_bvalid, n_bready, n_arvalid, n_rready;
    logic [31:0] n_wdata;
    logic [3:0]  n_wstrb;
    logic        n_busy, n_done, n_err, n_err_to;
    logic [1:0]  n_err_idx, n_err_kind;

    logic [3:0]  tab_addr [4];
    logic [31:0] tab_data [4];
    logic [31:0] mem [4];
    int          aw_dly [4], w_dly [4], ar_dly [4];
    bit          bad_b [4], bad_r [4], corrupt [4];
    bit          wstuck;
    int          aw_wait, w_wait, ar_wait, wi, ri;
    bit          have_aw, have_w;
    logic [3:0]  cap_addr;
    logic [31:0] cap_data;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    assign tbl_addr = tab_addr[tbl_idx];
    assign tbl_data = tab_data[tbl_idx];

    vfp_cfg_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4), .VERIFY(1), .TIMEOUT(TMO)) u_dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx), .err_kind(err_kind), .err_to(err_to)
    );

    // Write-only instance on an always-ready slave.
    vfp_cfg_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4), .VERIFY(0), .TIMEOUT(TMO)) u_dut_nv (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(n_start),
        .tbl_idx(n_tbl_idx), .tbl_addr(tab_addr[n_tbl_idx]), .tbl_data(tab_data[n_tbl_idx]),
        .m_axi_awaddr(n_awaddr), .m_axi_awprot(n_awprot), .m_axi_awvalid(n_awvalid), .m_axi_awready(1'b1),
        .m_axi_wdata(n_wdata), .m_axi_wstrb(n_wstrb), .m_axi_wvalid(n_wvalid), .m_axi_wready(1'b1),
        .m_axi_bresp(2'b00), .m_axi_bvalid(n_bvalid), .m_axi_bready(n_bready),
        .m_axi_araddr(n_araddr), .m_axi_arprot(n_arprot), .m_axi_arvalid(n_arvalid), .m_axi_arready(1'b1),
        .m_axi_rdata(32'h0), .m_axi_rresp(2'b00), .m_axi_rvalid(1'b0), .m_axi_rready(n_rready),
        .busy(n_busy), .done(n_done), .err(n_err), .err_idx(n_err_idx), .err_kind(n_err_kind), .err_to(n_err_to)
    );

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) n_bvalid <= 1'b0;
        else if (n_awvalid && n_wvalid) n_bvalid <= 1'b1;
        else if (n_bvalid && n_bready) n_bvalid <= 1'b0;
    end

    assign awready = awvalid && (aw_wait >= aw_dly[wi % 4]);
    assign wready  = wvalid && !wstuck && (w_wait >= w_dly[wi % 4]);
    assign arready = arvalid && (ar_wait >= ar_dly[ri % 4]);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; wi <= 0; ri <= 0;
            have_aw <= 1'b0; have_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0; cap_addr <= 4'h0; cap_data <= 32'h0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) cap_addr <= awaddr;
            if (wvalid && wready) cap_data <= wdata;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((have_aw || (awvalid && awready)) && (have_w || (wvalid && wready)) && !bvalid) begin
                mem[(awvalid && awready) ? awaddr[3:2] : cap_addr[3:2]] <= (wvalid && wready) ? wdata : cap_data;
                bvalid  <= 1'b1;
                bresp   <= bad_b[wi % 4] ? 2'b10 : 2'b00;
                wi      <= wi + 1;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
            end else begin
                have_aw <= have_aw || (awvalid && awready);
                have_w  <= have_w || (wvalid && wready);
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= corrupt[ri % 4] ? 32'hDEAD : mem[araddr[3:2]];
                rresp  <= bad_r[ri % 4] ? 2'b10 : 2'b00;
                ri     <= ri + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 4; i++) begin
            aw_dly[i] = 0; w_dly[i] = 0; ar_dly[i] = 0;
            bad_b[i] = 0; bad_r[i] = 0; corrupt[i] = 0;
            tab_addr[i] = 4'(i * 4);
            tab_data[i] = 32'(i + 1);
        end
        wstuck = 0;
    endtask

    task automatic do_reset();
        @(negedge ACLK); ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    // Pulse start, count edges until done (start-sampling edge counts as 1);
    // an optional second start pulse is raised while the edge count equals extra_at.
    task automatic run_seq(input int extra_at, output int n, output logic busy_after);
        @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK); #1;
        n = 1;
        start = 1'b0;
        while (!done && n < 2000) begin
            start = (n == extra_at);
            @(posedge ACLK); #1;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        start = (n == extra_at);
        @(posedge ACLK); #1;
        start = 1'b0;
        busy_after = busy;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4; i++) chk({tag, "_mem"}, mem[i], tab_data[i]);
    endtask

    typedef struct {
        int aw_d1; int w_d1; int bad_b_e; int corr_e; bit stuck;
        bit exp_err; int exp_idx; int exp_kind; bit exp_to; int exp_cyc;
    } vec_t;

    vec_t vecs [5];
    int   n;
    logic ba;
    int   exp_cyc, ek, ei;

    initial begin
        vecs[0] = '{0, 0, -1, -1, 0, 0, 0, 0, 0, 25};
        vecs[1] = '{3, 5, -1, -1, 0, 0, 0, 0, 0, 30};
        vecs[2] = '{0, 0,  2, -1, 0, 1, 2, 1, 0, 25};
        vecs[3] = '{0, 0, -1,  3, 0, 1, 3, 3, 0, 25};
        vecs[4] = '{0, 0, -1, -1, 1, 1, 0, 3, 1, -1};
        clear_cfg();
        for (int i = 0; i < 4; i++) mem[i] = 32'hFFFF_FFFF;

        #1;
        chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0); chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);   chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);       chk("rst_err", err, 0);
        chk("rst_err_kind", err_kind, 0); chk("rst_tbl_idx", tbl_idx, 0);
        chk("rst_awaddr", awaddr, 0);   chk("rst_wdata", wdata, 0);
        chk("rst_nv_busy", n_busy, 0);
        do_reset();

        for (int v = 0; v < 5; v++) begin
            clear_cfg();
            for (int i = 0; i < 4; i++) mem[i] = 32'hFFFF_FFFF;
            aw_dly[1] = vecs[v].aw_d1;
            w_dly[1]  = vecs[v].w_d1;
            if (vecs[v].bad_b_e >= 0) bad_b[vecs[v].bad_b_e] = 1;
            if (vecs[v].corr_e >= 0) corrupt[vecs[v].corr_e] = 1;
            wstuck = vecs[v].stuck;
            do_reset();
            run_seq(-1, n, ba);
            if (vecs[v].exp_cyc >= 0) chk($sformatf("v%0d_cycles", v), n, vecs[v].exp_cyc);
            else chk($sformatf("v%0d_tmo_window", v), (n >= TMO && n <= TMO + 5) ? 1 : 0, 1);
            chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("v%0d_err_idx", v), err_idx, vecs[v].exp_idx);
            chk($sformatf("v%0d_err_kind", v), err_kind, vecs[v].exp_kind);
            chk($sformatf("v%0d_err_to", v), err_to, vecs[v].exp_to);
            chk($sformatf("v%0d_valids_low", v), {awvalid, wvalid, arvalid, bready, rready}, 0);
            chk($sformatf("v%0d_busy_after", v), ba, 0);
            if (!vecs[v].stuck) check_mem($sformatf("v%0d", v));
        end

        // Error clears on the next start; extra start pulses while busy and during done are ignored.
        clear_cfg(); bad_b[0] = 1;
        do_reset();
        run_seq(5, n, ba);
        chk("hs_err_first_run", err, 1);
        chk("hs_busy_start_ignored", n, 25);
        bad_b[0] = 0;
        run_seq(25, n, ba);
        chk("hs_err_cleared", err, 0);
        chk("hs_kind_cleared", err_kind, 0);
        chk("hs_done_start_ignored", ba, 0);

        // Reset in the middle of the read-back of entry 1, then a clean rerun.
        clear_cfg(); corrupt[0] = 1;
        do_reset();
        @(negedge ACLK); start = 1'b1;
        @(posedge ACLK); #1; start = 1'b0;
        n = 1;
        while (!(rready && tbl_idx == 2'd1) && n < 200) begin
            @(posedge ACLK); #1; n++;
        end
        chk("rs_reached_rd1", (rready && tbl_idx == 2'd1) ? 1 : 0, 1);
        chk("rs_err_before", err, 1);
        #2 ARESETN = 1'b0;
        #1;
        chk("rs_outputs_zero", {awvalid, wvalid, bready, arvalid, rready, busy, done, err, err_to}, 0);
        chk("rs_idx_zero", {tbl_idx, err_idx, err_kind}, 0);
        chk("rs_addr_data_zero", {awaddr, araddr, wdata}, 0);
        @(negedge ACLK); ARESETN = 1'b1;
        corrupt[0] = 0;
        run_seq(-1, n, ba);
        chk("rs_rerun_cycles", n, 25);
        chk("rs_rerun_err", err, 0);

        // Write-only instance.
        @(negedge ACLK); n_start = 1'b1;
        @(posedge ACLK); #1; n_start = 1'b0;
        n = 1;
        while (!n_done && n < 200) begin
            @(posedge ACLK); #1; n++;
        end
        chk("nv_cycles", n, 13);
        chk("nv_err", n_err, 0);
        chk("nv_no_reads", n_arvalid, 0);

        // Randomized runs against a per-entry latency and first-error model.
        for (int r = 0; r < 20; r++) begin
            clear_cfg();
            exp_cyc = 1;
            for (int i = 0; i < 4; i++) begin
                tab_data[i] = $urandom;
                aw_dly[i] = $urandom_range(0, 3);
                w_dly[i] = $urandom_range(0, 3);
                ar_dly[i] = $urandom_range(0, 3);
                bad_b[i] = ($urandom_range(0, 7) == 0);
                bad_r[i] = ($urandom_range(0, 7) == 0);
                corrupt[i] = ($urandom_range(0, 7) == 0);
                exp_cyc += 3 + ((aw_dly[i] > w_dly[i]) ? aw_dly[i] : w_dly[i]);
                exp_cyc += 3 + ar_dly[i];
            end
            ek = 0; ei = 0;
            for (int i = 0; i < 4; i++) if (ek == 0 && bad_b[i]) begin ek = 1; ei = i; end
            for (int i = 0; i < 4; i++) begin
                if (ek == 0 && bad_r[i]) begin ek = 2; ei = i; end
                else if (ek == 0 && corrupt[i]) begin ek = 3; ei = i; end
            end
            do_reset();
            run_seq(-1, n, ba);
            chk($sformatf("r%0d_cycles", r), n, exp_cyc);
            chk($sformatf("r%0d_err", r), err, (ek != 0) ? 1 : 0);
            chk($sformatf("r%0d_err_kind", r), err_kind, ek);
            chk($sformatf("r%0d_err_idx", r), err_idx, ei);
            chk($sformatf("r%0d_err_to", r), err_to, 0);
            check_mem($sformatf("r%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
